// File: rtl/depacketizer_mc.sv
// depacketizer_mc: multi-channel depacketizer with an output FIFO.
// A header beat selects a channel and announces a beat count. When the
// announced count equals PAYLOAD_WIDTH/PACKET_WIDTH, the channel is valid and
// the FIFO has room, the data beats are assembled LSB-first into one payload.
// The payload is queued together with its channel ID. Any other header is
// skipped for its announced length.
// Optional feature: define DEPACK_MC_ERR_CNT_EN to add the saturating 8-bit
// err_cnt_o, which counts entries into the drop state.
module depacketizer_mc #(
    parameter int PAYLOAD_WIDTH = 128,
    parameter int PACKET_WIDTH  = 16,
    parameter int N_CH          = 4,
    parameter int CH_BITS       = 2,
    parameter int N_PKTS_BITS   = 4,
    parameter int DEPTH         = 4,
    parameter int DEPTH_LOG     = 2,
    parameter int AF_LVL        = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PACKET_WIDTH-1:0]  packet_i,
    output logic                     packet_af_o,
    output logic [PAYLOAD_WIDTH-1:0] payload_o,
    output logic [CH_BITS-1:0]       payload_ch_o,
    output logic                     payload_valid_o,
    input  logic                     payload_ready_i,
    output logic                     overflow_o,
`ifdef DEPACK_MC_ERR_CNT_EN
    output logic [7:0]               err_cnt_o,
`endif
    output logic                     len_err_o
);

    localparam int N_PKTS = PAYLOAD_WIDTH / PACKET_WIDTH;
    localparam logic [N_PKTS_BITS-1:0] N_PKTS_L = N_PKTS_BITS'(N_PKTS);
    localparam logic [DEPTH_LOG:0]     DEPTH_L  = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [DEPTH_LOG:0]     AF_L     = (DEPTH_LOG + 1)'(AF_LVL);
    localparam logic [CH_BITS:0]       N_CH_L   = (CH_BITS + 1)'(N_CH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DROP    = 2'd2
    } state_t;

    state_t                   state_q;
    logic [N_PKTS_BITS-1:0]   cnt_q;
    logic [CH_BITS-1:0]       ch_q;
    logic [PAYLOAD_WIDTH-1:0] payload_q;
    logic                     overflow_q;
    logic                     len_err_q;

    logic [PAYLOAD_WIDTH-1:0] mem_pl_q [DEPTH];
    logic [CH_BITS-1:0]       mem_ch_q [DEPTH];
    logic [DEPTH_LOG-1:0]     wr_q;
    logic [DEPTH_LOG-1:0]     rd_q;
    logic [DEPTH_LOG:0]       occ_q;
    logic [DEPTH_LOG:0]       occ_d;

    logic                     hdr_valid_s;
    logic [CH_BITS-1:0]       hdr_ch_s;
    logic [N_PKTS_BITS-1:0]   hdr_len_s;
    logic                     hdr_start_s;
    logic                     len_bad_s;
    logic                     ch_ok_s;
    logic                     space_s;
    logic                     drop_entry_s;
    logic                     pop_s;
    logic                     push_s;
    logic [N_PKTS_BITS-1:0]   beat_idx_s;
    logic [PAYLOAD_WIDTH-1:0] payload_asm_s;
    logic [DEPTH_LOG:0]       free_s;

    // Header field decode; only meaningful while the FSM sits in IDLE.
    assign hdr_valid_s = packet_i[0];
    assign hdr_ch_s    = packet_i[CH_BITS:1];
    assign hdr_len_s   = packet_i[CH_BITS+N_PKTS_BITS:CH_BITS+1];
    assign hdr_start_s = (state_q == IDLE) && hdr_valid_s && (hdr_len_s != '0);
    assign len_bad_s   = (hdr_len_s != N_PKTS_L);
    assign ch_ok_s     = ({1'b0, hdr_ch_s} < N_CH_L);

    // A pop in the header cycle frees a slot, so a full FIFO being drained still has room.
    assign pop_s        = payload_valid_o && payload_ready_i;
    assign space_s      = (occ_q != DEPTH_L) || pop_s;
    assign drop_entry_s = hdr_start_s && (len_bad_s || !ch_ok_s || !space_s);

    // Push happens on the last collected beat; room was reserved at the header.
    // No other push can intervene, so the push can never overflow the FIFO.
    assign push_s     = (state_q == COLLECT) && (cnt_q == N_PKTS_BITS'(1));
    assign beat_idx_s = N_PKTS_L - cnt_q;

    // Merge the current beat into its LSB-first slot of the partial payload.
    always_comb begin
        payload_asm_s = payload_q;
        if (state_q == COLLECT) begin
            for (int i = 0; i < N_PKTS; i++) begin
                if (beat_idx_s == N_PKTS_BITS'(i)) begin
                    payload_asm_s[i*PACKET_WIDTH +: PACKET_WIDTH] = packet_i;
                end else begin
                    payload_asm_s[i*PACKET_WIDTH +: PACKET_WIDTH] = payload_q[i*PACKET_WIDTH +: PACKET_WIDTH];
                end
            end
        end else begin
            payload_asm_s = payload_q;
        end
    end

    // Next occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        occ_d = occ_q;
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + (DEPTH_LOG + 1)'(1);
            2'b01:   occ_d = occ_q - (DEPTH_LOG + 1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Transaction FSM with beat counter, channel latch, payload assembly and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ch_q       <= '0;
            payload_q  <= '0;
            overflow_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hdr_start_s && len_bad_s) begin
                        state_q   <= DROP;
                        cnt_q     <= hdr_len_s;
                        len_err_q <= 1'b1;
                    end else if (hdr_start_s && !ch_ok_s) begin
                        state_q <= DROP;
                        cnt_q   <= hdr_len_s;
                    end else if (hdr_start_s && !space_s) begin
                        state_q    <= DROP;
                        cnt_q      <= N_PKTS_L;
                        overflow_q <= 1'b1;
                    end else if (hdr_start_s) begin
                        state_q <= COLLECT;
                        cnt_q   <= N_PKTS_L;
                        ch_q    <= hdr_ch_s;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                COLLECT: begin
                    payload_q <= payload_asm_s;
                    cnt_q     <= cnt_q - N_PKTS_BITS'(1);
                    state_q   <= (cnt_q == N_PKTS_BITS'(1)) ? IDLE : COLLECT;
                end
                DROP: begin
                    cnt_q   <= cnt_q - N_PKTS_BITS'(1);
                    state_q <= (cnt_q == N_PKTS_BITS'(1)) ? IDLE : DROP;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Output FIFO storage and pointers; the head entry is read show-ahead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pl_q[i] <= '0;
                mem_ch_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            if (push_s) begin
                mem_pl_q[wr_q] <= payload_asm_s;
                mem_ch_q[wr_q] <= ch_q;
                wr_q           <= wr_q + DEPTH_LOG'(1);
            end
            if (pop_s) begin
                rd_q <= rd_q + DEPTH_LOG'(1);
            end
            occ_q <= occ_d;
        end
    end

`ifdef DEPACK_MC_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of dropped transactions, whatever the reason.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (drop_entry_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end else begin
            err_cnt_q <= err_cnt_q;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

    assign free_s          = DEPTH_L - occ_q;
    assign packet_af_o     = (free_s <= AF_L);
    assign payload_valid_o = (occ_q != '0);
    assign payload_o       = mem_pl_q[rd_q];
    assign payload_ch_o    = mem_ch_q[rd_q];
    assign overflow_o      = overflow_q;
    assign len_err_o       = len_err_q;

endmodule
